// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the multicycle MIPS unified memory port.
// Serialises CPU (port 0) and DMA/loader (port 1) accesses with fixed wait states.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned   CW        = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_START = CW'(LATENCY - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          lastg_q, lastg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      lastg_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lastg_q <= lastg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lastg_d = lastg_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    rdata   = '0;
    mem_adr = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the port that did not win last time is granted.
          grant   = (req0 && req1) ? ~lastg_q : req1;
          owner_d = grant;
          lastg_d = grant;
          cnt_d   = CNT_START;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy    = 1'b1;
        mem_adr = owner_q ? addr1 : addr0;
        mem_wd  = owner_q ? wdata1 : wdata0;
        // Write strobe only in the first access cycle: one strobe per write.
        if (cnt_q == CNT_START) mem_we = owner_q ? we1 : we0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ack0    = ~owner_q;
          ack1    = owner_q;
          rdata   = mem_rd;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner = owner_q;

endmodule
